add64_share_ctrl: RTL and testbench

- Round-robin scheduler that shares one combinational 64-bit adder instance among NUM_REQ requesters. Example requesters: branch-target calc, address-gen, PC increment in the slow path.
- Accepts one operand pair at a time, drives it onto the shared adder, registers the sum, and returns it to the granted requester with a valid/ready response handshake.

---
 rtl/add64_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_add64_share_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add64_share_ctrl.sv
// Round-robin arbiter that time-shares one external 64-bit adder among NUM_REQ requesters.
// Optional performance counters are built when ADD64_SHARE_CTRL_PERF_EN is defined.
module add64_share_ctrl #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [64*NUM_REQ-1:0]   req_a,
  input  logic [64*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [63:0]             resp_data,
  output logic [63:0]             add_a,
  output logic [63:0]             add_b,
  input  logic [63:0]             add_result,
  output logic                    busy
`ifdef ADD64_SHARE_CTRL_PERF_EN
  ,
  output logic [31:0]             perf_ops,
  output logic [31:0]             perf_stall
`endif
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_RESP
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    owner;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W:0]      cand;
  logic [IDX_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;

  // Circular search for the first valid requester starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a = req_a[DATA_W*i +: DATA_W];
        sel_b = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  assign next_ptr     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign grant_onehot = NUM_REQ'(1) << grant_idx;
  assign req_ready    = (reset_n && (state == S_IDLE) && grant_found) ? grant_onehot : '0;
  assign add_a        = op_a;
  assign add_b        = op_b;

  // Control FSM; operand registers are left untouched in IDLE so the adder stays quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_data  <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            owner  <= grant_idx;
            rr_ptr <= next_ptr;
            busy   <= 1'b1;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          resp_data  <= add_result;
          resp_valid <= NUM_REQ'(1) << owner;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready[owner]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ADD64_SHARE_CTRL_PERF_EN
  logic handshake;
  logic stalled;

  assign handshake = (state == S_RESP) && resp_ready[owner];
  assign stalled   = |(req_valid & ~req_ready);

  // Saturating counters for completed operations and waiting-requester cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (handshake && (perf_ops != '1)) begin
        perf_ops <= perf_ops + 32'(1);
      end
      if (stalled && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_add64_share_ctrl.sv
// Randomized bench for add64_share_ctrl against a transaction-level round-robin/sum model.
module tb_add64_share_ctrl;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [64*N-1:0]   req_a = '0;
  logic [64*N-1:0]   req_b = '0;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready = '0;
  logic [63:0]       resp_data;
  logic [63:0]       add_a;
  logic [63:0]       add_b;
  logic [63:0]       add_result;
  logic              busy;
`ifdef ADD64_SHARE_CTRL_PERF_EN
  logic [31:0]       perf_ops;
  logic [31:0]       perf_stall;
`endif

  add64_share_ctrl #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .busy       (busy)
`ifdef ADD64_SHARE_CTRL_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  // The shared adder lives outside the controller.
  assign add_result = add_a + add_b;

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit [N-1:0]  pend     = '0;
  logic [63:0] pa [N];
  logic [63:0] pb [N];
  int          mptr     = 0;
  logic [63:0] last_a   = '0;
  logic [63:0] last_b   = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int pick(input bit [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return 64'h0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pend[i];
      req_a[64*i +: 64]   = pa[i];
      req_b[64*i +: 64]   = pb[i];
    end
  endtask

  // Called on a falling edge; resets the DUT and the model, returns on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    drive();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_add_a", add_a, 64'(0));
    chk("rst_add_b", add_b, 64'(0));
    chk("rst_resp_data", resp_data, 64'(0));
`ifdef ADD64_SHARE_CTRL_PERF_EN
    chk("rst_perf_ops", 64'(perf_ops), 64'(0));
    chk("rst_perf_stall", 64'(perf_stall), 64'(0));
`endif
    @(negedge clk);
    reset_n = 1'b1;
    mptr    = 0;
    last_a  = '0;
    last_b  = '0;
  endtask

  // One IDLE cycle plus, if something is granted, the full op through its response handshake.
  task automatic one_op(input int stall, input bit keep, output int g);
    logic [63:0]  ea, eb, sum;
    logic [N-1:0] oh;
    drive();
    #1;
    g = pick(pend, mptr);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_resp_valid", 64'(resp_valid), 64'(0));
    chk("idle_hold_a", add_a, last_a);
    chk("idle_hold_b", add_b, last_b);
    if (g < 0) begin
      chk("idle_no_grant", 64'(req_ready), 64'(0));
      @(negedge clk);
      return;
    end
    oh    = '0;
    oh[g] = 1'b1;
    chk("grant", 64'(req_ready), 64'(oh));
    ea   = pa[g];
    eb   = pb[g];
    sum  = ea + eb;
    mptr = (g + 1) % N;
    @(negedge clk);
    if (keep) begin
      pa[g] = rand64();
      pb[g] = rand64();
    end else begin
      pend[g] = 1'b0;
    end
    drive();
    #1;
    chk("add_busy", 64'(busy), 64'(1));
    chk("add_req_ready", 64'(req_ready), 64'(0));
    chk("add_resp_valid", 64'(resp_valid), 64'(0));
    chk("add_a", add_a, ea);
    chk("add_b", add_b, eb);
    @(negedge clk);
    chk("resp_valid", 64'(resp_valid), 64'(oh));
    chk("resp_data", resp_data, sum);
    chk("resp_busy", 64'(busy), 64'(1));
    chk("resp_req_ready", 64'(req_ready), 64'(0));
    for (int s = 0; s < stall; s++) begin
      resp_ready = N'($urandom) & ~oh;
      @(negedge clk);
      chk("stall_resp_valid", 64'(resp_valid), 64'(oh));
      chk("stall_resp_data", resp_data, sum);
      chk("stall_req_ready", 64'(req_ready), 64'(0));
    end
    resp_ready = N'($urandom) | oh;
    @(negedge clk);
    resp_ready = '0;
    last_a = ea;
    last_b = eb;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    #2;
    do_reset();

    // Single op on requester 2 with a carry across bit 32.
    pend  = 4'b0100;
    pa[2] = 64'h0000_0001_FFFF_FFFF;
    pb[2] = 64'h1;
    one_op(0, 1'b0, g);
    chk("single_grant", 64'(g), 64'(2));
    chk("single_sum", last_a + last_b, 64'h0000_0002_0000_0000);

    // Sum wraps modulo 2^64.
    pend  = 4'b0001;
    pa[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    pb[0] = 64'h2;
    one_op(0, 1'b0, g);
    chk("wrap_grant", 64'(g), 64'(0));

    // All requesters continuously valid from reset.
    do_reset();
    pend = '1;
    for (int i = 0; i < N; i++) begin
      pa[i] = rand64();
      pb[i] = rand64();
    end
    for (int k = 0; k < 5; k++) begin
      one_op(0, 1'b1, g);
      chk("rr_order", 64'(g), 64'(exp_order[k]));
    end

    // Five cycles of response backpressure.
    one_op(5, 1'b0, g);
    chk("bp_grant", 64'(g), 64'(1));

    // Reset during ADD discards the op and restarts the pointer.
    pend  = 4'b0010;
    pa[1] = rand64();
    pb[1] = rand64();
    drive();
    #1;
    chk("abort_grant", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    chk("abort_in_add", 64'(busy), 64'(1));
    pend = 4'b1001;
    do_reset();
    one_op(0, 1'b0, g);
    chk("post_reset_grant", 64'(g), 64'(0));

`ifdef ADD64_SHARE_CTRL_PERF_EN
    do_reset();
    pend = 4'b0011;
    one_op(0, 1'b0, g);
    chk("perf_ops", 64'(perf_ops), 64'(1));
    chk("perf_stall", 64'(perf_stall), 64'(3));
`endif

    // Random traffic with withdrawals and backpressure.
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          pa[i]   = rand64();
          pb[i]   = rand64();
        end else if (pend[i] && ($urandom_range(0, 9) == 0)) begin
          pend[i] = 1'b0;
        end
      end
      one_op(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
